// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first; done pulses WIDTH+1 cycles after start is accepted.
// No backpressure: start is ignored while busy, and Diff/Bout/Ovf hold until the next done.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] d_sh;
  logic [WIDTH-1:0] d_new;
  logic [CW-1:0]    cnt;
  logic             br, br_nxt, bit_d, a0, b0, accept;

  assign a0     = a_sh[0];
  assign b0     = b_sh[0];
  assign bit_d  = a0 ^ b0 ^ br;
  assign br_nxt = (~a0 & b0) | (~(a0 ^ b0) & br);
  assign d_new  = {bit_d, d_sh};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done   = 1'b1;
        accept = start;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      d_sh <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      Diff <= '0;
      Bout <= 1'b0;
      Ovf  <= 1'b0;
    end else if (accept) begin
      a_sh <= A;
      b_sh <= B;
      d_sh <= '0;
      br   <= Bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      d_sh <= d_new[WIDTH-1:1];
      br   <= br_nxt;
      cnt  <= cnt + CW'(1);
      // On the MSB step a0/b0 are the operand sign bits and bit_d is the result sign.
      if (cnt == LAST) begin
        Diff <= d_new;
        Bout <= br_nxt;
        Ovf  <= (a0 != b0) && (bit_d != a0);
      end
    end
  end

endmodule
